// File: rtl/alu_op_issuer_if.sv
// ---------------------------------------------------------------------------
// alu_op_issuer_if
//   Bundles the three faces of the ALU issuer: the command port from the
//   datapath control, the operand/opcode/result wiring to the combinational
//   ALU, and the response port carrying the captured Z register.
//
//   Signals
//     cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b : command handshake + payload
//     alu_a/alu_b/alu_op                     : registered ALU inputs
//     alu_result                             : combinational ALU output
//     rsp_valid/rsp_ready/rsp_zhi/rsp_zlo/rsp_err : response handshake + Z
//     busy                                   : issuer not idle
//
//   Modports
//     master : the issuer itself
//     slave  : the surrounding control/ALU environment
// ---------------------------------------------------------------------------
interface alu_op_issuer_if #(
    parameter int DATA_W = 32
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [3:0]          cmd_op;
    logic [DATA_W-1:0]   cmd_a;
    logic [DATA_W-1:0]   cmd_b;

    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [3:0]          alu_op;
    logic [2*DATA_W-1:0] alu_result;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_zhi;
    logic [DATA_W-1:0]   rsp_zlo;
    logic                rsp_err;

    logic                busy;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b,
        output cmd_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result,
        output rsp_valid, rsp_zhi, rsp_zlo, rsp_err,
        input  rsp_ready,
        output busy
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result,
        input  rsp_valid, rsp_zhi, rsp_zlo, rsp_err,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/alu_op_issuer.sv
// ---------------------------------------------------------------------------
// alu_op_issuer
//   Issues one operation at a time to a combinational ALU. A command is
//   latched onto the ALU inputs, the issuer waits an opcode-dependent number
//   of cycles, then captures the 2*DATA_W result into ZHI/ZLO and offers it
//   on the response port until it is taken.
//
//   Ports
//     clock : rising-edge clock
//     clear : synchronous active-high reset, overrides everything
//     bus   : alu_op_issuer_if.master (command, ALU wiring, response, busy)
//
//   Latency parameters (each must be >= 1):
//     MUL_LAT for op 4, DIV_LAT for op 5, BASE_LAT for every other legal op.
// ---------------------------------------------------------------------------
module alu_op_issuer #(
    parameter int DATA_W   = 32,
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 4,
    parameter int BASE_LAT = 1
) (
    input  logic           clock,
    input  logic           clear,
    alu_op_issuer_if.master bus
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT)
                           ? ((MUL_LAT > BASE_LAT) ? MUL_LAT : BASE_LAT)
                           : ((DIV_LAT > BASE_LAT) ? DIV_LAT : BASE_LAT);
    // Counter only ever holds L-1, so log2(MAX_LAT) bits suffice.
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [3:0] OP_MUL = 4'd4;
    localparam logic [3:0] OP_DIV = 4'd5;
    localparam logic [3:0] OP_LIM = 4'd13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state_reg,  state_next;
    logic [CNT_W-1:0]    cnt_reg,    cnt_next;
    logic [DATA_W-1:0]   alu_a_reg,  alu_a_next;
    logic [DATA_W-1:0]   alu_b_reg,  alu_b_next;
    logic [3:0]          alu_op_reg, alu_op_next;
    logic [DATA_W-1:0]   zhi_reg,    zhi_next;
    logic [DATA_W-1:0]   zlo_reg,    zlo_next;
    logic                err_reg,    err_next;

    logic                reject;
    logic [CNT_W-1:0]    lat_m1;

    // Illegal opcodes and divide-by-zero never reach EXEC.
    assign reject = (bus.cmd_op >= OP_LIM) ||
                    ((bus.cmd_op == OP_DIV) && (bus.cmd_b == '0));

    always_comb begin
        lat_m1 = CNT_W'(BASE_LAT - 1);
        if (bus.cmd_op == OP_MUL) begin
            lat_m1 = CNT_W'(MUL_LAT - 1);
        end else if (bus.cmd_op == OP_DIV) begin
            lat_m1 = CNT_W'(DIV_LAT - 1);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            alu_a_reg  <= '0;
            alu_b_reg  <= '0;
            alu_op_reg <= '0;
            zhi_reg    <= '0;
            zlo_reg    <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            alu_a_reg  <= alu_a_next;
            alu_b_reg  <= alu_b_next;
            alu_op_reg <= alu_op_next;
            zhi_reg    <= zhi_next;
            zlo_reg    <= zlo_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        alu_a_next  = alu_a_reg;
        alu_b_next  = alu_b_reg;
        alu_op_next = alu_op_reg;
        zhi_next    = zhi_reg;
        zlo_next    = zlo_reg;
        err_next    = err_reg;

        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    alu_a_next = bus.cmd_a;
                    alu_b_next = bus.cmd_b;
                    if (reject) begin
                        // Park the ALU on a harmless opcode for rejects.
                        alu_op_next = '0;
                        zhi_next    = '0;
                        zlo_next    = '0;
                        err_next    = 1'b1;
                        state_next  = HOLD;
                    end else begin
                        alu_op_next = bus.cmd_op;
                        cnt_next    = lat_m1;
                        state_next  = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    zlo_next = bus.alu_result[DATA_W-1:0];
                    // Only multiply and divide produce a meaningful upper word.
                    if ((alu_op_reg == OP_MUL) || (alu_op_reg == OP_DIV)) begin
                        zhi_next = bus.alu_result[2*DATA_W-1:DATA_W];
                    end else begin
                        zhi_next = '0;
                    end
                    err_next   = 1'b0;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = (state_reg == IDLE);
    assign bus.rsp_valid = (state_reg == HOLD);
    assign bus.busy      = (state_reg != IDLE);
    assign bus.alu_a     = alu_a_reg;
    assign bus.alu_b     = alu_b_reg;
    assign bus.alu_op    = alu_op_reg;
    assign bus.rsp_zhi   = zhi_reg;
    assign bus.rsp_zlo   = zlo_reg;
    assign bus.rsp_err   = err_reg;

endmodule

// File: tb/tb_alu_op_issuer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_issuer
//   Self-checking bench for alu_op_issuer. A behavioural ALU answers the
//   issuer's registered inputs; it deliberately fills the upper word with
//   a pattern for single-width ops so that ZHI clearing is observable.
//   A vector table covers every opcode class; hand sequences cover a
//   zero-backpressure add, sustained backpressure and a mid-op clear.
// ---------------------------------------------------------------------------
module tb_alu_op_issuer;
    localparam int DATA_W = 32;

    logic clock;
    logic clear;

    alu_op_issuer_if #(.DATA_W(DATA_W)) bus ();

    alu_op_issuer #(
        .DATA_W   (DATA_W),
        .MUL_LAT  (2),
        .DIV_LAT  (4),
        .BASE_LAT (1)
    ) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in combinational ALU.
    function automatic logic [63:0] alu_model(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] junk;
        logic [4:0]  s;
        logic [63:0] r;
        junk = 32'hA5A5_A5A5;
        s    = b[4:0];
        r    = '0;
        case (op)
            4'd0:  r = {junk, a & b};
            4'd1:  r = {junk, a | b};
            4'd2:  r = {junk, a + b};
            4'd3:  r = {junk, a - b};
            4'd4:  r = {32'd0, a} * {32'd0, b};
            4'd5:  r = (b == 0) ? 64'd0 : {a % b, a / b};
            4'd6:  r = {junk, a >> s};
            4'd7:  r = {junk, 32'($signed(a) >>> s)};
            4'd8:  r = {junk, a << s};
            4'd9:  r = {junk, (a >> s) | (a << (6'd32 - {1'b0, s}))};
            4'd10: r = {junk, (a << s) | (a >> (6'd32 - {1'b0, s}))};
            4'd11: r = {junk, -a};
            4'd12: r = {junk, ~a};
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    always_comb bus.alu_result = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] zhi;
        logic [31:0] zlo;
        logic        err;
        int          lat;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clock);
        chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = v.op;
        bus.cmd_a     = v.a;
        bus.cmd_b     = v.b;
        bus.rsp_ready = 1'b0;
        @(posedge clock);
        #1;
        // Scribble on the command bus while busy; must be ignored.
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = 32'h5555_5555;
        bus.cmd_op    = 4'd3;
        @(negedge clock);
        chk("alu_op_latch", 64'(bus.alu_op), v.err ? 64'd0 : 64'(v.op));
        chk("alu_a_latch", 64'(bus.alu_a), 64'(v.a));
        chk("busy_after_accept", 64'(bus.busy), 64'd1);
        lat = 0;
        if (v.err) begin
            @(posedge clock);
            @(negedge clock);
            chk("rej_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("rej_alu_op", 64'(bus.alu_op), 64'd0);
        end else begin
            chk("exec_no_rsp", 64'(bus.rsp_valid), 64'd0);
            while (!bus.rsp_valid && lat < 64) begin
                @(posedge clock);
                lat++;
                @(negedge clock);
            end
            chk("latency", 64'(lat), 64'(v.lat));
        end
        chk("rsp_err", 64'(bus.rsp_err), 64'(v.err));
        chk("rsp_zhi", 64'(bus.rsp_zhi), 64'(v.zhi));
        chk("rsp_zlo", 64'(bus.rsp_zlo), 64'(v.zlo));
        $display("[TB] op=%0d a=%h b=%h -> zhi=%h zlo=%h err=%0b lat=%0d",
                 v.op, v.a, v.b, bus.rsp_zhi, bus.rsp_zlo, bus.rsp_err, lat);
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clock);
        chk("idle_after_rsp", 64'(bus.busy), 64'd0);
        chk("rsp_valid_drop", 64'(bus.rsp_valid), 64'd0);
        chk("zlo_retained", 64'(bus.rsp_zlo), 64'(v.zlo));
    endtask

    // Global watchdog so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        vec_t v;

        //            op     a              b              zhi            zlo            err lat
        vecs[0]  = '{4'd0,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h0,         32'h00F0_1200, 1'b0, 1};
        vecs[1]  = '{4'd1,  32'h1200_0034, 32'h0034_1200, 32'h0,         32'h1234_1234, 1'b0, 1};
        vecs[2]  = '{4'd2,  32'd12,        32'd28,        32'h0,         32'd40,        1'b0, 1};
        vecs[3]  = '{4'd2,  32'hFFFF_FFFF, 32'd2,         32'h0,         32'd1,         1'b0, 1};
        vecs[4]  = '{4'd3,  32'd5,         32'd7,         32'h0,         32'hFFFF_FFFE, 1'b0, 1};
        vecs[5]  = '{4'd4,  32'h0001_0000, 32'h0001_0000, 32'h1,         32'h0,         1'b0, 2};
        vecs[6]  = '{4'd4,  32'd3,         32'd4,         32'h0,         32'd12,        1'b0, 2};
        vecs[7]  = '{4'd4,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 2};
        vecs[8]  = '{4'd5,  32'd24,        32'd12,        32'h0,         32'd2,         1'b0, 4};
        vecs[9]  = '{4'd5,  32'd25,        32'd12,        32'h1,         32'd2,         1'b0, 4};
        vecs[10] = '{4'd5,  32'd24,        32'd0,         32'h0,         32'h0,         1'b1, 0};
        vecs[11] = '{4'd6,  32'h8000_0000, 32'd4,         32'h0,         32'h0800_0000, 1'b0, 1};
        vecs[12] = '{4'd7,  32'h8000_0000, 32'd4,         32'h0,         32'hF800_0000, 1'b0, 1};
        vecs[13] = '{4'd8,  32'd1,         32'd31,        32'h0,         32'h8000_0000, 1'b0, 1};
        vecs[14] = '{4'd9,  32'd1,         32'd1,         32'h0,         32'h8000_0000, 1'b0, 1};
        vecs[15] = '{4'd10, 32'h8000_0001, 32'd4,         32'h0,         32'h0000_0018, 1'b0, 1};
        vecs[16] = '{4'd11, 32'd1,         32'd0,         32'h0,         32'hFFFF_FFFF, 1'b0, 1};
        vecs[17] = '{4'd12, 32'd4,         32'd0,         32'h0,         32'hFFFF_FFFB, 1'b0, 1};
        vecs[18] = '{4'd13, 32'd7,         32'd9,         32'h0,         32'h0,         1'b1, 0};
        vecs[19] = '{4'd15, 32'd7,         32'd9,         32'h0,         32'h0,         1'b1, 0};

        clear         = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 4'd2;
        bus.cmd_a     = 32'd1;
        bus.cmd_b     = 32'd1;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        // clear must win over a pending command.
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_alu_op", 64'(bus.alu_op), 64'd0);
        chk("rst_alu_a", 64'(bus.alu_a), 64'd0);
        chk("rst_zlo", 64'(bus.rsp_zlo), 64'd0);
        chk("rst_err", 64'(bus.rsp_err), 64'd0);
        bus.cmd_valid = 1'b0;
        clear         = 1'b0;

        // Add with the consumer always ready.
        @(negedge clock);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 4'd2;
        bus.cmd_a     = 32'd12;
        bus.cmd_b     = 32'd28;
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clock);
        chk("add_alu_op", 64'(bus.alu_op), 64'd2);
        chk("add_no_rsp_yet", 64'(bus.rsp_valid), 64'd0);
        @(negedge clock);
        chk("add_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("add_zlo", 64'(bus.rsp_zlo), 64'd40);
        chk("add_zhi", 64'(bus.rsp_zhi), 64'd0);
        chk("add_err", 64'(bus.rsp_err), 64'd0);
        @(negedge clock);
        chk("add_busy_low", 64'(bus.busy), 64'd0);
        $display("[TB] add ready=1: zlo=%h zhi=%h", bus.rsp_zlo, bus.rsp_zhi);
        bus.rsp_ready = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: NOT with the consumer stalled for three cycles.
        @(negedge clock);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 4'd12;
        bus.cmd_a     = 32'd4;
        bus.cmd_b     = 32'd0;
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clock);
        lat = 0;
        while (!bus.rsp_valid && lat < 64) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        chk("bp_latency", 64'(lat), 64'd1);
        for (int c = 0; c < 3; c++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 4'd2;
            bus.cmd_a     = 32'd99;
            @(posedge clock);
            @(negedge clock);
            chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
            chk("bp_zlo", 64'(bus.rsp_zlo), 64'hFFFF_FFFB);
            chk("bp_alu_op", 64'(bus.alu_op), 64'd12);
            chk("bp_alu_a", 64'(bus.alu_a), 64'd4);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clock);
        chk("bp_idle", 64'(bus.busy), 64'd0);
        chk("bp_idle_alu_op", 64'(bus.alu_op), 64'd12);
        chk("bp_idle_zlo", 64'(bus.rsp_zlo), 64'hFFFF_FFFB);
        $display("[TB] backpressure not: zlo=%h held %0d cycles", bus.rsp_zlo, 3);

        // clear two cycles into a divide.
        @(negedge clock);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 4'd5;
        bus.cmd_a     = 32'd24;
        bus.cmd_b     = 32'd12;
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("clr_mid_busy", 64'(bus.busy), 64'd1);
        clear = 1'b1;
        @(posedge clock);
        #1 clear = 1'b0;
        @(negedge clock);
        chk("clr_busy", 64'(bus.busy), 64'd0);
        chk("clr_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("clr_alu_op", 64'(bus.alu_op), 64'd0);
        chk("clr_alu_a", 64'(bus.alu_a), 64'd0);
        chk("clr_alu_b", 64'(bus.alu_b), 64'd0);
        chk("clr_zlo", 64'(bus.rsp_zlo), 64'd0);
        chk("clr_zhi", 64'(bus.rsp_zhi), 64'd0);
        @(negedge clock);
        chk("clr_no_late_rsp", 64'(bus.rsp_valid), 64'd0);
        $display("[TB] clear mid-divide: busy=%0b rsp_valid=%0b", bus.busy, bus.rsp_valid);

        v = '{4'd1, 32'd1, 32'd0, 32'h0, 32'd1, 1'b0, 1};
        run_vec(v);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
- Command-side initiator for the combinational ALU (a, b, op -> 64-bit result).
- Accepts one operation at a time over a valid/ready command port and drives the ALU operand and opcode inputs.
- Waits an opcode-dependent number of cycles, then captures the 64-bit ALU result into a Z register split into ZHI/ZLO.
- Returns the result over a valid/ready response port. Sits between the datapath control and the ALU.

Parameters:
- DATA_W, 32, operand width; ALU result is 2*DATA_W.
- MUL_LAT, 2, cycles spent in EXEC for op 4 (multiply); must be >= 1.
- DIV_LAT, 4, cycles spent in EXEC for op 5 (divide); must be >= 1.
- BASE_LAT, 1, cycles spent in EXEC for all other valid ops; must be >= 1.

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  issuer can accept a command
- cmd_op  in  4  ALU opcode: 0 and, 1 or, 2 add, 3 sub, 4 mul, 5 div, 6 shr, 7 shra, 8 shl, 9 ror, 10 rol, 11 neg, 12 not
- cmd_a  in  DATA_W  operand A
- cmd_b  in  DATA_W  operand B
- alu_a  out  DATA_W  to ALU a
- alu_b  out  DATA_W  to ALU b
- alu_op  out  4  to ALU op
- alu_result  in  2*DATA_W  from ALU result (combinational)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_zhi  out  DATA_W  upper result word
- rsp_zlo  out  DATA_W  lower result word
- rsp_err  out  1  command rejected (illegal op or divide by zero)
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values (clear=1 at an edge): state IDLE; alu_a=0, alu_b=0, alu_op=0; rsp_zhi=0, rsp_zlo=0, rsp_err=0, rsp_valid=0; counter=0. clear has priority over all other inputs.
- States: IDLE, EXEC, HOLD. Outputs are decoded from the state: cmd_ready=1 only in IDLE; rsp_valid=1 only in HOLD.
- IDLE, on an edge where cmd_valid=1:
  - Latch cmd_a, cmd_b and cmd_op into alu_a, alu_b and alu_op.
  - If cmd_op >= 13, or (cmd_op == 5 and cmd_b == 0): go to HOLD with rsp_err=1, rsp_zhi=0, rsp_zlo=0. alu_op is forced to 0 in this case.
  - Otherwise load counter = L-1 and go to EXEC, where L is MUL_LAT for op 4, DIV_LAT for op 5, and BASE_LAT for all others.
- EXEC:
  - alu_a, alu_b and alu_op are held stable.
  - If counter != 0, decrement it.
  - If counter == 0: capture into Z and go to HOLD with rsp_err=0.
    - rsp_zlo = alu_result[DATA_W-1:0].
    - rsp_zhi = alu_result[2*DATA_W-1:DATA_W] for op 4 and op 5; forced to 0 for every other op.
- Latency: if the command is accepted at edge E, rsp_valid rises after edge E+L. Rejected commands respond after edge E+1.
- HOLD:
  - rsp_zhi, rsp_zlo and rsp_err are stable while rsp_ready=0.
  - On an edge with rsp_ready=1, go to IDLE. rsp_zhi, rsp_zlo and rsp_err retain their values until the next capture.
  - No command is accepted in the same cycle as a response handshake (cmd_ready=0 in HOLD). Maximum throughput is one op per L+2 cycles.
- In IDLE, alu_a, alu_b and alu_op keep their last values; they do not toggle.
- cmd_* inputs are ignored outside IDLE; changing them while busy has no effect.
- clear asserted mid-EXEC or in HOLD aborts the operation and discards the result. All outputs return to their reset values on that edge; the next command is accepted normally.
- No overflow or carry flag. Signedness is entirely the ALU's; the issuer only slices words.

Test Plan:
- Add, with rsp_ready=1: accept op=2, a=12, b=28 at edge E. Required: alu_op=2 after E; rsp_valid=1 after E+1; zlo=40, zhi=0, err=0; busy low after E+2.
- Multiply: op=4, a=0x00010000, b=0x00010000, MUL_LAT=2. Required: rsp_valid after E+2; zhi=0x00000001, zlo=0x00000000. Separately, a=3, b=4 gives zlo=12, zhi=0.
- Divide, then divide by zero:
  - op=5, a=24, b=12, DIV_LAT=4. Required: rsp_valid after E+4; zlo=2, zhi=alu_result[63:32] (0 for the bench ALU).
  - op=5, b=0. Required: err=1 and zhi=zlo=0 after E+1; alu_op=0.
- Illegal op and backpressure:
  - op=13. Required: err=1 after E+1.
  - op=12, a=4, with rsp_ready held 0 for 3 cycles. Required: zlo=0xFFFFFFFB and rsp_valid held stable; cmd_ready=0 throughout; cmd_valid pulses meanwhile are not accepted.
- Reset mid-op: op=5 (DIV_LAT=4), clear=1 two cycles after accept. Required: next cycle state IDLE, rsp_valid=0, all outputs 0. A following op=1, a=1, b=0 returns zlo=1.
